// File: rtl/mem_write_checker_pkg.sv
// Shared types and default sizing for the MIPS data-memory write checker.
package mips_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } checker_state_t;

    localparam int DATA_W_DEF      = 16;
    localparam int ADDR_W_DEF      = 8;
    localparam int DEPTH_DEF       = 4;
    localparam int IGNORE_ADDR_DEF = 80;
    localparam int TIMEOUT_DEF     = 1024;

    // A DEPTH of 1 still needs a one-bit index port.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Data-memory store bus as seen by dmem; the checker only ever listens on it.
interface mem_write_checker_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;

    modport master (output memwrite, dataadr, writedata);
    modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_checker_exp_table.sv
// Expected-store table: one registered write port, one combinational read port.
// Reads past DEPTH return zero; writes past DEPTH are dropped; reset clears every entry.
module exp_table #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CNT_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (wr_en && (int'(wr_idx) < DEPTH)) begin
            addr_q[wr_idx] <= wr_addr;
            data_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_addr = '0;
        rd_data = '0;
        if (int'(rd_idx) < DEPTH) begin
            rd_addr = addr_q[rd_idx[IDX_W-1:0]];
            rd_data = data_q[rd_idx[IDX_W-1:0]];
        end
    end
endmodule

// File: rtl/mem_write_checker.sv
// Checks observed dmem stores against an ordered expected table; verdict registered one edge
// after the deciding store. Pure monitor: never stalls the bus.
module mem_write_checker
    import mips_test_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int IGNORE_EN   = 1,
    parameter int IGNORE_ADDR = IGNORE_ADDR_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    localparam int IDX_W      = idx_w(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int TMR_W      = $clog2(TIMEOUT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 exp_we,
    input  logic [IDX_W-1:0]     exp_idx,
    input  logic [ADDR_W-1:0]    exp_addr,
    input  logic [DATA_W-1:0]    exp_data,
    input  logic [CNT_W-1:0]     exp_count,
    mem_write_checker_if.slave   bus,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [IDX_W-1:0]     fail_idx,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [DATA_W-1:0]    fail_data,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [7:0]           ignore_cnt
);
    checker_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, match_q, match_d;
    logic [7:0]        ign_q, ign_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              pass_q, pass_d, fail_q, fail_d, to_q, to_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d, rd_addr;
    logic [DATA_W-1:0] fdata_q, fdata_d, rd_data;
    logic              hit, ign_hit, expired;

    exp_table #(
        .DEPTH (DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (exp_we && (state_q != RUN)),
        .wr_idx  (exp_idx),
        .wr_addr (exp_addr),
        .wr_data (exp_data),
        .rd_idx  (match_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign hit     = bus.memwrite && (bus.dataadr == rd_addr) && (bus.writedata == rd_data);
    assign ign_hit = (IGNORE_EN != 0) && bus.memwrite && (bus.dataadr == ADDR_W'(IGNORE_ADDR));
    assign expired = (timer_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        ign_d   = ign_q;
        timer_d = timer_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        to_d    = to_q;
        fidx_d  = fidx_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                cnt_d   = (int'(exp_count) > DEPTH) ? CNT_W'(DEPTH) : exp_count;
                match_d = '0;
                ign_d   = '0;
                timer_d = '0;
                pass_d  = 1'b0;
                fail_d  = 1'b0;
                to_d    = 1'b0;
                fidx_d  = '0;
                faddr_d = '0;
                fdata_d = '0;
            end
        end else begin
            timer_d = timer_q + TMR_W'(1);
            if (cnt_q == '0) begin
                state_d = PASS;
                pass_d  = 1'b1;
            end else if (hit) begin
                match_d = match_q + CNT_W'(1);
                if (match_d == cnt_q) begin
                    state_d = PASS;
                    pass_d  = 1'b1;
                end else if (expired) begin
                    state_d = FAIL;
                    fail_d  = 1'b1;
                    to_d    = 1'b1;
                    fidx_d  = match_d[IDX_W-1:0];
                end
            end else if (bus.memwrite && !ign_hit) begin
                state_d = FAIL;
                fail_d  = 1'b1;
                fidx_d  = match_q[IDX_W-1:0];
                faddr_d = bus.dataadr;
                fdata_d = bus.writedata;
            end else begin
                if (ign_hit && (ign_q != 8'hFF)) ign_d = ign_q + 8'd1;
                if (expired) begin
                    state_d = FAIL;
                    fail_d  = 1'b1;
                    to_d    = 1'b1;
                    fidx_d  = match_q[IDX_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            match_q <= '0;
            ign_q   <= '0;
            timer_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            to_q    <= 1'b0;
            fidx_q  <= '0;
            faddr_q <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            ign_q   <= ign_d;
            timer_q <= timer_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            to_q    <= to_d;
            fidx_q  <= fidx_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
        end
    end

    assign done       = pass_q | fail_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = to_q;
    assign fail_idx   = fidx_q;
    assign fail_addr  = faddr_q;
    assign fail_data  = fdata_q;
    assign match_cnt  = match_q;
    assign ignore_cnt = ign_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a scratch-tolerant, short-timeout instance plus a strict one.
module tb_mem_write_checker;
    import mips_test_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start, exp_we;
    logic [IW-1:0] exp_idx;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_count;

    mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          done, pass, fail, timeout;
    logic [IW-1:0] fail_idx;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [CW-1:0] match_cnt;
    logic [7:0]    ignore_cnt;

    logic          done_n, pass_n, fail_n, timeout_n;
    logic [IW-1:0] fail_idx_n;
    logic [AW-1:0] fail_addr_n;
    logic [DW-1:0] fail_data_n;
    logic [CW-1:0] match_cnt_n;
    logic [7:0]    ignore_cnt_n;

    mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .IGNORE_EN(1),
                        .IGNORE_ADDR(80), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count), .bus(bus),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout), .fail_idx(fail_idx),
        .fail_addr(fail_addr), .fail_data(fail_data), .match_cnt(match_cnt),
        .ignore_cnt(ignore_cnt)
    );

    mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .IGNORE_EN(0),
                        .IGNORE_ADDR(80), .TIMEOUT(1024)) dut_n (
        .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count), .bus(bus),
        .done(done_n), .pass(pass_n), .fail(fail_n), .timeout(timeout_n),
        .fail_idx(fail_idx_n), .fail_addr(fail_addr_n), .fail_data(fail_data_n),
        .match_cnt(match_cnt_n), .ignore_cnt(ignore_cnt_n)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          p;
        logic [CW-1:0] m;
        logic [7:0]    ic;
    } vec_t;

    typedef struct {
        logic          p;
        logic          f;
        logic [CW-1:0] m;
        logic [7:0]    ic;
    } exp_t;

    vec_t vecs [7];
    exp_t sb [$];
    exp_t e;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int idx, input int a, input int d);
        exp_we   = 1'b1;
        exp_idx  = IW'(idx);
        exp_addr = AW'(a);
        exp_data = DW'(d);
        cyc();
        exp_we = 1'b0;
    endtask

    task automatic begin_run(input int cnt, input string name);
        exp_count = CW'(cnt);
        start     = 1'b1;
        cyc();
        start     = 1'b0;
        check({name, "_done_clr"}, {31'd0, done}, 0);
        check({name, "_match_clr"}, {29'd0, match_cnt}, 0);
    endtask

    task automatic wr(input int a, input int d);
        bus.memwrite  = 1'b1;
        bus.dataadr   = AW'(a);
        bus.writedata = DW'(d);
        cyc();
        bus.memwrite  = 1'b0;
        bus.dataadr   = AW'($urandom);
        bus.writedata = DW'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; exp_we = 1'b0; exp_idx = '0;
        exp_addr = '0; exp_data = '0; exp_count = '0;
        bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;
        idle(2);
        check("rst_done", {31'd0, done}, 0);
        check("rst_fail", {31'd0, fail}, 0);
        check("rst_match", {29'd0, match_cnt}, 0);
        check("rst_ign", {24'd0, ignore_cnt}, 0);
        reset = 1'b1;
        cyc();

        // Single entry with one tolerated scratch write ahead of it.
        prog(0, 60, 28);
        begin_run(1, "t1");
        wr(80, 5);
        check("t1_wait_pass", {31'd0, pass}, 0);
        check("t1_wait_ign", {24'd0, ignore_cnt}, 1);
        wr(60, 28);
        check("t1_pass", {31'd0, pass}, 1);
        check("t1_done", {31'd0, done}, 1);
        check("t1_ign", {24'd0, ignore_cnt}, 1);
        check("t1_match", {29'd0, match_cnt}, 1);
        check("t1_timeout", {31'd0, timeout}, 0);
        check("t1_fail", {31'd0, fail}, 0);

        // Three ordered entries with scratch writes and a quiet cycle interleaved.
        vecs[0] = '{1'b1, 8'd4,  16'd1,  1'b0, 3'd1, 8'd0};
        vecs[1] = '{1'b1, 8'd80, 16'd9,  1'b0, 3'd1, 8'd1};
        vecs[2] = '{1'b1, 8'd8,  16'd2,  1'b0, 3'd2, 8'd1};
        vecs[3] = '{1'b0, 8'd60, 16'd99, 1'b0, 3'd2, 8'd1};
        vecs[4] = '{1'b1, 8'd80, 16'd3,  1'b0, 3'd2, 8'd2};
        vecs[5] = '{1'b1, 8'd60, 16'd28, 1'b1, 3'd3, 8'd2};
        vecs[6] = '{1'b1, 8'd1,  16'd1,  1'b1, 3'd3, 8'd2};
        prog(0, 4, 1);
        prog(1, 8, 2);
        prog(2, 60, 28);
        begin_run(3, "t2");
        for (int i = 0; i < 7; i++) begin
            bus.memwrite  = vecs[i].we;
            bus.dataadr   = vecs[i].a;
            bus.writedata = vecs[i].d;
            sb.push_back('{vecs[i].p, 1'b0, vecs[i].m, vecs[i].ic});
            cyc();
            e = sb.pop_front();
            check($sformatf("t2_pass[%0d]", i), {31'd0, pass}, {31'd0, e.p});
            check($sformatf("t2_fail[%0d]", i), {31'd0, fail}, {31'd0, e.f});
            check($sformatf("t2_match[%0d]", i), {29'd0, match_cnt}, {29'd0, e.m});
            check($sformatf("t2_ign[%0d]", i), {24'd0, ignore_cnt}, {24'd0, e.ic});
        end
        bus.memwrite = 1'b0;

        // Data mismatch, then a late correct write must not rescue the run.
        prog(0, 60, 28);
        begin_run(1, "t3");
        wr(60, 27);
        check("t3_fail", {31'd0, fail}, 1);
        check("t3_idx", {30'd0, fail_idx}, 0);
        check("t3_addr", {24'd0, fail_addr}, 60);
        check("t3_data", {16'd0, fail_data}, 27);
        check("t3_timeout", {31'd0, timeout}, 0);
        wr(60, 28);
        check("t3_still_fail", {31'd0, fail}, 1);
        check("t3_no_pass", {31'd0, pass}, 0);

        // Scratch write: strict instance fails, tolerant instance then times out.
        begin_run(1, "t4");
        wr(80, 7);
        check("t4_strict_fail", {31'd0, fail_n}, 1);
        check("t4_strict_addr", {24'd0, fail_addr_n}, 80);
        check("t4_strict_data", {16'd0, fail_data_n}, 7);
        check("t4_tol_fail", {31'd0, fail}, 0);
        idle(14);
        check("t4_edge15_fail", {31'd0, fail}, 0);
        idle(1);
        check("t4_edge16_fail", {31'd0, fail}, 1);
        check("t4_timeout", {31'd0, timeout}, 1);
        check("t4_to_idx", {30'd0, fail_idx}, 0);
        check("t4_to_addr", {24'd0, fail_addr}, 0);
        check("t4_to_data", {16'd0, fail_data}, 0);
        check("t4_ign", {24'd0, ignore_cnt}, 1);

        // Completing match and mismatch landing on the timeout edge.
        begin_run(1, "t5a");
        idle(15);
        wr(60, 28);
        check("t5a_pass", {31'd0, pass}, 1);
        check("t5a_timeout", {31'd0, timeout}, 0);
        check("t5a_fail", {31'd0, fail}, 0);
        begin_run(1, "t5b");
        idle(15);
        wr(60, 27);
        check("t5b_fail", {31'd0, fail}, 1);
        check("t5b_timeout", {31'd0, timeout}, 0);
        check("t5b_addr", {24'd0, fail_addr}, 60);
        check("t5b_data", {16'd0, fail_data}, 27);

        // Empty table passes one edge after entering RUN.
        begin_run(0, "t6");
        check("t6_run_pass", {31'd0, pass}, 0);
        cyc();
        check("t6_pass", {31'd0, pass}, 1);
        check("t6_done", {31'd0, done}, 1);

        // Asynchronous abort mid-run, cleared table, then a table write during RUN.
        prog(0, 4, 1);
        prog(1, 8, 2);
        begin_run(2, "t7");
        wr(4, 1);
        check("t7_match1", {29'd0, match_cnt}, 1);
        #1 reset = 1'b0;
        #1;
        check("t7_rst_match", {29'd0, match_cnt}, 0);
        check("t7_rst_done", {31'd0, done}, 0);
        #1 reset = 1'b1;
        begin_run(1, "t7c");
        wr(0, 0);
        check("t7_cleared_pass", {31'd0, pass}, 1);
        prog(0, 4, 1);
        prog(1, 8, 2);
        begin_run(2, "t7r");
        exp_we = 1'b1; exp_idx = 2'd1; exp_addr = 8'd9; exp_data = 16'd9;
        wr(4, 1);
        exp_we = 1'b0;
        wr(8, 2);
        check("t7_run_we_pass", {31'd0, pass}, 1);
        check("t7_run_we_match", {29'd0, match_cnt}, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, self-checking monitor on the single-cycle MIPS data-memory write bus (memwrite/dataadr/writedata).
- Compares observed stores against a programmable ordered table of up to DEPTH expected (address, data) pairs.
- Tolerates writes to one configurable scratch address and enforces a cycle timeout; reports pass/fail with captured failure details.
- Sits beside dmem in the top-level and replaces open-coded pass/fail checks, so results are visible both on silicon and in simulation.

Parameters:
- DATA_W, 16, width of writedata / expected data
- ADDR_W, 8, width of dataadr / expected address
- DEPTH, 4, maximum number of expected writes (at least 1)
- IGNORE_EN, 1, enables tolerance of writes to IGNORE_ADDR
- IGNORE_ADDR, 80, scratch address whose non-matching writes are skipped
- TIMEOUT, 1024, cycles allowed in RUN before forced failure (at least 2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a check run (honoured in IDLE, PASS, FAIL)
- exp_we  in  1  write one expected-table entry
- exp_idx  in  $clog2(DEPTH)  table index for exp_we
- exp_addr  in  ADDR_W  expected address
- exp_data  in  DATA_W  expected data
- exp_count  in  $clog2(DEPTH+1)  number of valid entries, sampled at start
- memwrite  in  1  observed store strobe
- dataadr  in  ADDR_W  observed store address
- writedata  in  DATA_W  observed store data
- done  out  1  run finished (pass or fail), sticky
- pass  out  1  all expected writes seen in order, sticky
- fail  out  1  mismatch or timeout, sticky
- timeout  out  1  failure caused by the timer
- fail_idx  out  $clog2(DEPTH)  table index at failure
- fail_addr  out  ADDR_W  offending dataadr (0 on timeout)
- fail_data  out  DATA_W  offending writedata (0 on timeout)
- match_cnt  out  $clog2(DEPTH+1)  entries matched so far
- ignore_cnt  out  8  tolerated scratch writes, saturates at 255

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Table contents are cleared to 0.
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE, PASS or FAIL with start=1: go to RUN next edge. On that edge match_cnt, ignore_cnt, timer and all fail_* outputs clear; done/pass/fail/timeout drop; exp_count is latched.
  - start=1 with latched exp_count==0: go to RUN, then PASS on the following edge.
  - start while in RUN is ignored.
- Table programming: exp_we writes entry exp_idx on a rising edge in any state except RUN. In RUN it is ignored. An exp_idx at or beyond DEPTH is ignored.
- RUN: the timer increments every cycle. On each edge with memwrite=1 the checker evaluates, in priority order:
  1. dataadr/writedata equal entry[match_cnt]: match_cnt increments. If this is entry exp_count-1, go to PASS.
  2. IGNORE_EN and dataadr==IGNORE_ADDR: ignore_cnt increments (saturating); no state change.
  3. Otherwise: go to FAIL. Capture fail_idx=match_cnt and fail_addr/fail_data from the bus.
- Timeout: in RUN, when the timer reaches TIMEOUT-1 with no PASS, go to FAIL with timeout=1, fail_idx=match_cnt, fail_addr=0, fail_data=0.
- Same-edge timeout and completing match: the match wins (PASS).
- Same-edge timeout and mismatch: mismatch capture is used and timeout=0.
- memwrite=0: the bus is not checked; its values are don't-care.
- Outputs are registered. Result flags assert on the edge that samples the deciding write (latency 1 cycle from the bus presenting it).
- done = pass | fail, with pass and fail mutually exclusive. All are sticky until start or reset.
- Reset mid-RUN aborts immediately to IDLE with outputs 0. The table is lost and must be reprogrammed.

Decomposition:
- Package mips_test_pkg:
  - checker_state_t enum {IDLE, RUN, PASS, FAIL}
  - default constants for DATA_W, ADDR_W, IGNORE_ADDR, TIMEOUT
- Sub-module exp_table: DEPTH x (ADDR_W+DATA_W) register array with one write port and one combinational read port indexed by match_cnt; asynchronous active-low clear.
- FSM, timer and capture logic live in mem_write_checker.

Test Plan:
- Single entry (60,28), exp_count=1; start; bus writes (80,5) then (60,28) -> pass=1, done=1, ignore_cnt=1, match_cnt=1, timeout=0.
- Three entries (4,1),(8,2),(60,28); bus writes in order with (80,x) interleaved -> pass=1 one cycle after the (60,28) write, match_cnt=3.
- Entry (60,28); bus writes (60,27) -> fail=1, fail_idx=0, fail_addr=60, fail_data=27. A subsequent (60,28) write leaves fail=1 and pass=0.
- Entry (60,28) with IGNORE_EN=0; bus writes (80,7) -> fail=1, fail_addr=80, fail_data=7.
- TIMEOUT=16; no memwrite after start -> fail=1, timeout=1 on the 16th RUN cycle. Completing match on that same cycle -> pass=1, timeout=0.
- Reset low mid-RUN after one match -> all outputs 0 immediately (asynchronous), state IDLE. Reprogram table, start -> normal pass; exp_we during RUN does not alter the table.
